// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. It receives a byte stream on a valid/ready
// interface, assembles little-endian 32-bit words and writes them to RAM
// starting at word index BaseWord. A trailing additive checksum is then
// verified. The core is released from reset only after a successful load.
//
// Stream layout (all fields little-endian):
//   LEN  : 4 bytes, word count N
//   DATA : N words of 4 bytes each
//   CSUM : 4 bytes, sum of all N words mod 2^32
//
// Ports:
//   clk_sys_i       system clock
//   rst_sys_ni      asynchronous active-low reset
//   byte_valid_i    stream byte valid
//   byte_data_i     stream byte
//   byte_ready_o    loader can take a byte (transfer = valid && ready)
//   mem_req_o       RAM write request
//   mem_we_o        RAM write enable (same as mem_req_o)
//   mem_addr_o      RAM word address
//   mem_wdata_o     RAM write data
//   mem_be_o        RAM byte enables (all ones while requesting)
//   mem_gnt_i       RAM grant; the write completes on the grant edge
//   restart_i       synchronous abort / reload request
//   core_rst_no     active-low core reset (0 = core held in reset)
//   done_o          load finished with a good checksum
//   error_o         load failed (bad length or bad checksum)
//   words_loaded_o  number of words written so far
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int MemAw    = 14,
    parameter int BaseWord = 32,
    parameter int MaxWords = 2048
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [MemAw-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_gnt_i,
    input  logic             restart_i,
    output logic             core_rst_no,
    output logic             done_o,
    output logic             error_o,
    output logic [15:0]      words_loaded_o
);

    localparam int CntW = $clog2(MaxWords + 1);

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [1:0]       r_byte_cnt;
    logic [31:0]      r_shift;
    logic [31:0]      r_len;
    logic [CntW-1:0]  r_word_cnt;
    logic [31:0]      r_csum;
    logic [31:0]      r_wdata;
    logic             r_done;
    logic             r_error;
    logic             r_core_rst_n;

    logic             w_xfer;
    logic             w_last_byte;
    logic [31:0]      w_word;
    logic             w_last_word;

    // Ready is a pure decode of the state, so it never depends on valid.
    assign byte_ready_o = (r_state == ST_LEN) || (r_state == ST_DATA) ||
                          (r_state == ST_CSUM);
    assign w_xfer       = byte_valid_i && byte_ready_o;
    assign w_last_byte  = w_xfer && (r_byte_cnt == 2'd3);

    // The incoming byte becomes the MS byte, so the first byte of a word
    // ends up in bits [7:0] once the fourth byte arrives.
    assign w_word       = {byte_data_i, r_shift[31:8]};

    assign w_last_word  = (32'(r_word_cnt) + 32'd1) == r_len;

    // ---------------- state register ----------------
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_state <= ST_LEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LEN: begin
                if (w_last_byte) begin
                    if (w_word > 32'(MaxWords)) begin
                        w_state_next = ST_ERROR;
                    end else if (w_word == 32'd0) begin
                        w_state_next = ST_CSUM;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_last_byte) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_gnt_i) begin
                    w_state_next = w_last_word ? ST_CSUM : ST_DATA;
                end
            end
            ST_CSUM: begin
                if (w_last_byte) begin
                    w_state_next = (w_word == r_csum) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE:  w_state_next = ST_DONE;
            ST_ERROR: w_state_next = ST_ERROR;
            default:  w_state_next = ST_LEN;
        endcase
        // Restart wins over any simultaneous byte transfer or grant.
        if (restart_i) begin
            w_state_next = ST_LEN;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_byte_cnt   <= 2'd0;
            r_shift      <= 32'd0;
            r_len        <= 32'd0;
            r_word_cnt   <= '0;
            r_csum       <= 32'd0;
            r_wdata      <= 32'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else if (restart_i) begin
            r_byte_cnt   <= 2'd0;
            r_shift      <= 32'd0;
            r_len        <= 32'd0;
            r_word_cnt   <= '0;
            r_csum       <= 32'd0;
            r_wdata      <= 32'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_shift    <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;   // wraps to 0 after byte 4
            end
            if ((r_state == ST_LEN) && w_last_byte) begin
                r_len <= w_word;
            end
            if ((r_state == ST_DATA) && w_last_byte) begin
                r_wdata <= w_word;
            end
            if ((r_state == ST_WRITE) && mem_gnt_i) begin
                r_word_cnt <= r_word_cnt + 1'b1;
                r_csum     <= r_csum + r_wdata;
            end
            // Status flags follow the state being entered so they change
            // on the same edge as the final byte.
            r_done       <= (w_state_next == ST_DONE);
            r_core_rst_n <= (w_state_next == ST_DONE);
            r_error      <= (w_state_next == ST_ERROR);
        end
    end

    // ---------------- outputs ----------------
    assign mem_req_o      = (r_state == ST_WRITE);
    assign mem_we_o       = mem_req_o;
    assign mem_be_o       = mem_req_o ? 4'hF : 4'h0;
    assign mem_addr_o     = MemAw'(BaseWord) + MemAw'(r_word_cnt);
    assign mem_wdata_o    = r_wdata;
    assign core_rst_no    = r_core_rst_n;
    assign done_o         = r_done;
    assign error_o        = r_error;
    assign words_loaded_o = 16'(r_word_cnt);

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Directed bench for prog_loader. Stimulus pushes the expected RAM writes
// into a queue; an independent monitor pops and compares on every granted
// write. Status outputs are checked at the end of each stream.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int MemAw = 14;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             mem_req;
    logic             mem_we;
    logic [MemAw-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_gnt;
    logic             restart;
    logic             core_rst_n;
    logic             done;
    logic             error;
    logic [15:0]      words_loaded;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [MemAw-1:0] addr;
        logic [31:0]      data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] buf_q[$];

    always #5 clk = ~clk;

    prog_loader #(
        .MemAw    (MemAw),
        .BaseWord (32),
        .MaxWords (2048)
    ) dut (
        .clk_sys_i      (clk),
        .rst_sys_ni     (rst_n),
        .byte_valid_i   (byte_valid),
        .byte_data_i    (byte_data),
        .byte_ready_o   (byte_ready),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_be_o       (mem_be),
        .mem_gnt_i      (mem_gnt),
        .restart_i      (restart),
        .core_rst_no    (core_rst_n),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a write completes on the edge after a negedge with req && gnt.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_gnt) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected none", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=%h be=%h", mem_addr, mem_wdata, mem_be);
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
                check("wr_be",   32'(mem_be), 32'h0000000F);
                check("wr_we",   32'(mem_we), 32'd1);
            end
        end
    end

    // Hand-computed writes of stream 1.
    task automatic push_stream1_writes();
        wr_t w;
        w.addr = 14'd32; w.data = 32'h00000013; exp_q.push_back(w);
        w.addr = 14'd33; w.data = 32'h123450b7; exp_q.push_back(w);
        w.addr = 14'd34; w.data = 32'h0000005d; exp_q.push_back(w);
    endtask

    task automatic load_stream1();
        buf_q = '{8'h03, 8'h00, 8'h00, 8'h00,  8'h13, 8'h00, 8'h00, 8'h00,
                  8'hb7, 8'h50, 8'h34, 8'h12,  8'h5d, 8'h00, 8'h00, 8'h00,
                  8'h27, 8'h51, 8'h34, 8'h12};
    endtask

    // Present each byte and hold it until accepted; returns 1 ns after the
    // accepting edge.
    task automatic send_buf(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int n;
            n = 0;
            byte_valid = 1'b1;
            byte_data  = buf_q[i];
            forever begin
                @(negedge clk);
                if (byte_ready) break;
                n++;
                if (n > 50) begin
                    total++;
                    bad++;
                    $display("FAIL byte_timeout: got no ready for byte %0d expected ready within 50 cycles", i);
                    break;
                end
            end
            @(posedge clk);
            #1;
            $display("byte %0d = %h sent", i, buf_q[i]);
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic check_load_ok(input string tag);
        check({tag, "_done"},    32'(done),         32'd1);
        check({tag, "_error"},   32'(error),        32'd0);
        check({tag, "_corerst"}, 32'(core_rst_n),   32'd1);
        check({tag, "_words"},   32'(words_loaded), 32'd3);
        check({tag, "_ready"},   32'(byte_ready),   32'd0);
        check({tag, "_pending"}, exp_q.size(),      32'd0);
    endtask

    // Absolute time limit so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        mem_gnt    = 1'b1;
        restart    = 1'b0;

        // Reset state
        #3;
        check("rst_ready",   32'(byte_ready),   32'd1);
        check("rst_req",     32'(mem_req),      32'd0);
        check("rst_corerst", 32'(core_rst_n),   32'd0);
        check("rst_done",    32'(done),         32'd0);
        check("rst_error",   32'(error),        32'd0);
        check("rst_words",   32'(words_loaded), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: good stream, grant tied high
        $display("scenario 1");
        load_stream1();
        push_stream1_writes();
        send_buf(0, 19);
        check_load_ok("s1");
        pulse_restart();

        // 2: bad checksum, then restart and reload
        $display("scenario 2");
        load_stream1();
        buf_q[16] = 8'h28;
        push_stream1_writes();
        send_buf(0, 19);
        check("s2_error",   32'(error),      32'd1);
        check("s2_done",    32'(done),       32'd0);
        check("s2_corerst", 32'(core_rst_n), 32'd0);
        check("s2_pending", exp_q.size(),    32'd0);
        pulse_restart();
        check("s2_rs_error", 32'(error),        32'd0);
        check("s2_rs_ready", 32'(byte_ready),   32'd1);
        check("s2_rs_words", 32'(words_loaded), 32'd0);
        load_stream1();
        push_stream1_writes();
        send_buf(0, 19);
        check_load_ok("s2r");
        pulse_restart();

        // 3: empty program
        $display("scenario 3");
        buf_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_buf(0, 6);
        check("s3_pre_done", 32'(done), 32'd0);
        send_buf(7, 7);
        check("s3_done",    32'(done),         32'd1);
        check("s3_corerst", 32'(core_rst_n),   32'd1);
        check("s3_words",   32'(words_loaded), 32'd0);
        pulse_restart();

        // 4: grant withheld for 5 cycles on the second write
        $display("scenario 4");
        load_stream1();
        push_stream1_writes();
        send_buf(0, 10);
        mem_gnt = 1'b0;
        send_buf(11, 11);
        byte_valid = 1'b1;
        byte_data  = buf_q[12];
        for (int c = 0; c < 6; c++) begin
            if (c == 5) begin
                @(posedge clk);
                #1;
                mem_gnt = 1'b1;
            end
            @(negedge clk);
            check("s4_req",   32'(mem_req),    32'd1);
            check("s4_addr",  32'(mem_addr),   32'd33);
            check("s4_data",  mem_wdata,       32'h123450b7);
            check("s4_ready", 32'(byte_ready), 32'd0);
        end
        send_buf(12, 19);
        check_load_ok("s4");
        pulse_restart();

        // 5: oversize length
        $display("scenario 5");
        buf_q = '{8'h01, 8'h08, 8'h00, 8'h00};
        send_buf(0, 3);
        check("s5_error", 32'(error),      32'd1);
        check("s5_done",  32'(done),       32'd0);
        check("s5_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("s5_req", 32'(mem_req), 32'd0);
        pulse_restart();

        // 6: asynchronous reset mid-load, then full reload
        $display("scenario 6");
        load_stream1();
        send_buf(0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_ready",   32'(byte_ready),   32'd1);
        check("s6_req",     32'(mem_req),      32'd0);
        check("s6_corerst", 32'(core_rst_n),   32'd0);
        check("s6_done",    32'(done),         32'd0);
        check("s6_words",   32'(words_loaded), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        push_stream1_writes();
        send_buf(0, 19);
        check_load_ok("s6");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
